// File: rtl/uart_tx_serializer_if.sv
// Byte-side and line-side signals of the UART transmit serializer.
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-deep holding register, frames paced by tx_clk rising edges.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 m_clk,
  input  logic                 reset,
  input  logic                 tx_clk,
  uart_tx_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic                   tx_clk_q;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_out_q, tx_out_d;
  logic                   done_q, done_d;
  logic                   busy_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic bit_tick;
  logic accept;
  logic drain;

  assign bit_tick = tx_clk & ~tx_clk_q;
  // accept and drain are mutually exclusive: one needs holding empty, the other full
  assign accept   = bus.tx_load & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    tx_out_d    = tx_out_q;
    done_d      = 1'b0;
    drain       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (bit_tick) begin
      unique case (state_q)
        IDLE: begin
          tx_out_d = 1'b1;
          if (hold_full_q) drain = 1'b1;
        end
        START: begin
          tx_out_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_out_d = par_q;
            state_d  = PARITY;
`else
            tx_out_d   = 1'b1;
            stop_cnt_d = '0;
            state_d    = STOP;
`endif
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_out_d   = 1'b1;
          stop_cnt_d = '0;
          state_d    = STOP;
        end
`endif
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              drain = 1'b1;
            end else begin
              tx_out_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame start is shared by IDLE and the back-to-back exit of STOP
    if (drain) begin
      shift_d    = hold_q;
      bit_cnt_d  = '0;
      stop_cnt_d = '0;
      tx_out_d   = 1'b0;
      state_d    = START;
`ifdef UART_TX_PARITY_EN
      par_d      = ^hold_q;
`endif
    end

    hold_d      = accept ? bus.tx_data[DATA_BITS-1:0] : hold_q;
    hold_full_d = drain ? 1'b0 : (accept ? 1'b1 : hold_full_q);
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tx_clk_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_out_q    <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tx_clk_q    <= tx_clk;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_out_q    <= tx_out_d;
      done_q      <= done_d;
      busy_q      <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bus.tx_ready = ~hold_full_q;
  assign bus.tx_out   = tx_out_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: 8N1 and 5-data/2-stop instances, 10-cycle bit period.
module tb_uart_tx_serializer;

  localparam int DB0 = 8;
  localparam int SB0 = 1;
  localparam int DB1 = 5;
  localparam int SB1 = 2;
  localparam int BITP = 10;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic m_clk  = 1'b0;
  logic reset  = 1'b1;
  logic tx_clk = 1'b0;

  always #5 m_clk = ~m_clk;
  initial begin
    #1;
    forever #50 tx_clk = ~tx_clk;
  end

  uart_tx_serializer_if bus0 ();
  uart_tx_serializer_if bus1 ();

  uart_tx_serializer dut0 (
    .m_clk  (m_clk),
    .reset  (reset),
    .tx_clk (tx_clk),
    .bus    (bus0)
  );

  uart_tx_serializer #(.DATA_BITS(DB1), .STOP_BITS(SB1)) dut1 (
    .m_clk  (m_clk),
    .reset  (reset),
    .tx_clk (tx_clk),
    .bus    (bus1)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  frame_t      q0[$];
  frame_t      q1[$];
  int          g1, g2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int inst);
    return (inst == 0) ? bus0.tx_out : bus1.tx_out;
  endfunction
  function automatic logic rdy(input int inst);
    return (inst == 0) ? bus0.tx_ready : bus1.tx_ready;
  endfunction
  function automatic logic bsy(input int inst);
    return (inst == 0) ? bus0.tx_busy : bus1.tx_busy;
  endfunction
  function automatic logic dn(input int inst);
    return (inst == 0) ? bus0.tx_done : bus1.tx_done;
  endfunction

  function automatic frame_t build(input int db, input int sb, input logic [7:0] d);
    frame_t f;
    int     n = 0;
    logic   p = 1'b0;
    f.bits = '0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < db; i++) begin
      f.bits[n] = d[i];
      p ^= d[i];
      n++;
    end
`ifdef UART_TX_PARITY_EN
    f.bits[n] = p;
    n++;
`endif
    for (int i = 0; i < sb; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  task automatic load(input int inst, input logic [7:0] d, input bit accept);
    @(negedge m_clk);
    check_eq($sformatf("ready_before_load%0d", inst), rdy(inst), accept);
    if (inst == 0) begin
      bus0.tx_data = d;
      bus0.tx_load = 1'b1;
    end else begin
      bus1.tx_data = d;
      bus1.tx_load = 1'b1;
    end
    if (accept) begin
      if (inst == 0) q0.push_back(build(DB0, SB0, d));
      else           q1.push_back(build(DB1, SB1, d));
    end
    @(posedge m_clk);
    #1;
    bus0.tx_load = 1'b0;
    bus1.tx_load = 1'b0;
    check_eq($sformatf("ready_after_load%0d", inst), rdy(inst), 1'b0);
  endtask

  task automatic mon_frame(input int inst, input bit aligned, input int budget, output int gap);
    frame_t e;
    int     dones = 0;
    int     pend;
    if (!aligned) @(negedge m_clk);
    gap = 0;
    while (line(inst) !== 1'b0 && gap < budget) begin
      @(negedge m_clk);
      gap++;
    end
    check_eq($sformatf("start_seen%0d", inst), line(inst), 1'b0);
    if (line(inst) !== 1'b0) return;
    pend = (inst == 0) ? q0.size() : q1.size();
    check_eq($sformatf("sb_pending%0d", inst), (pend != 0), 1'b1);
    if (pend == 0) return;
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    for (int i = 1; i <= e.len * BITP; i++) begin
      @(negedge m_clk);
      if (i < e.len * BITP) dones += int'(dn(inst));
      if (i == 5) check_eq($sformatf("busy_in_frame%0d", inst), bsy(inst), 1'b1);
      if (i % BITP == 5)
        check_eq($sformatf("bit%0d_inst%0d", (i - 5) / BITP, inst), line(inst), e.bits[(i - 5) / BITP]);
    end
    check_eq($sformatf("done_early%0d", inst), dones, 0);
    check_eq($sformatf("done_at_end%0d", inst), dn(inst), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    bus0.tx_data = '0;
    bus0.tx_load = 1'b0;
    bus1.tx_data = '0;
    bus1.tx_load = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge m_clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_tx_out%0d", i), line(i), 1'b1);
      check_eq($sformatf("rst_ready%0d", i), rdy(i), 1'b1);
      check_eq($sformatf("rst_busy%0d", i), bsy(i), 1'b0);
      check_eq($sformatf("rst_done%0d", i), dn(i), 1'b0);
    end
    reset = 1'b1;

    bad = 0;
    repeat (200) begin
      @(negedge m_clk);
      for (int i = 0; i < 2; i++)
        if (line(i) !== 1'b1 || rdy(i) !== 1'b1 || bsy(i) !== 1'b0 || dn(i) !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    fork
      mon_frame(0, 1'b0, 200, g1);
      load(0, 8'hA5, 1'b1);
    join

    fork
      mon_frame(1, 1'b0, 200, g1);
      load(1, 8'hFF, 1'b1);
    join
    fork
      mon_frame(1, 1'b0, 200, g1);
      load(1, 8'hE0, 1'b1);
    join

    fork
      begin
        mon_frame(0, 1'b0, 200, g1);
        mon_frame(0, 1'b1, 50, g2);
        check_eq("b2b_gap", g2, 0);
      end
      begin
        load(0, 8'h3C, 1'b1);
        k = 0;
        while (bus0.tx_busy !== 1'b1 && k < 40) begin
          @(negedge m_clk);
          k++;
        end
        check_eq("b2b_busy", bus0.tx_busy, 1'b1);
        load(0, 8'hC3, 1'b1);
        load(0, 8'h11, 1'b0);
      end
    join

    bad = 0;
    repeat (300) begin
      @(negedge m_clk);
      if (bus0.tx_out !== 1'b1 || bus0.tx_done !== 1'b0) bad++;
    end
    check_eq("no_third_frame", bad, 0);

    load(0, 8'h55, 1'b1);
    k = 0;
    while (bus0.tx_out !== 1'b0 && k < 30) begin
      @(negedge m_clk);
      k++;
    end
    check_eq("rst_start_seen", bus0.tx_out, 1'b0);
    repeat (4 * BITP + 3) @(negedge m_clk);
    check_eq("rst_mid_busy", bus0.tx_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mid_tx_out", bus0.tx_out, 1'b1);
    check_eq("rst_mid_ready", bus0.tx_ready, 1'b1);
    check_eq("rst_mid_busy_clr", bus0.tx_busy, 1'b0);
    q0.delete();
    bad = 0;
    repeat (20) begin
      @(negedge m_clk);
      if (bus0.tx_out !== 1'b1 || bus0.tx_done !== 1'b0) bad++;
    end
    reset = 1'b1;
    repeat (200) begin
      @(negedge m_clk);
      if (bus0.tx_out !== 1'b1 || bus0.tx_done !== 1'b0) bad++;
    end
    check_eq("rst_discard_quiet", bad, 0);

    fork
      mon_frame(0, 1'b0, 200, g1);
      load(0, 8'h96, 1'b1);
    join

    check_eq("sb_drained0", q0.size(), 0);
    check_eq("sb_drained1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
